// File: rtl/circular_pkg.sv
// rtl/circular_pkg.sv - shared state encoding and depth derivation for the capture buffer
package circular_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } cap_state_e;

    // Number of slots addressed by an aw-bit pointer.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/circular_ram.sv
// rtl/circular_ram.sv - simple dual-port slot storage, synchronous read, no reset
module circular_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    import circular_pkg::*;

    localparam int DEPTH = int'(depth_of(ADDR_WIDTH));

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port and registered read port; a same-slot read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/circular_capture_buffer.sv
// rtl/circular_capture_buffer.sv - circular sample buffer with arm/trigger/post-count freeze
module circular_capture_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_hit,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH-1:0] trig_addr
);
    import circular_pkg::*;

    localparam int DEPTH = int'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    cap_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  rd_valid_q;
    logic                  rd_hit_q;
    logic                  has_data_q;

    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] rd_slot;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign wr_acc  = wr_en && (state_q != ST_FROZEN);
    assign rd_slot = tail_q + rd_addr;

    circular_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_acc),
        .wr_addr(tail_q),
        .wr_data(data_in),
        .rd_en  (rd_req),
        .rd_addr(rd_slot),
        .rd_data(ram_rd_data)
    );

    // Next-state for capture FSM, pointers, fill level and valid flags.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        trig_addr_d = trig_addr_q;
        tail_d      = tail_q;
        fill_d      = fill_q;
        valid_d     = valid_q;

        if (wr_acc) begin
            tail_d          = tail_q + 1'b1;
            valid_d[tail_q] = 1'b1;
            if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The write in the trigger cycle is stored but not counted.
                if (trigger) begin
                    trig_addr_d = tail_q;
                    remaining_d = post_count;
                    state_d     = (post_count == '0) ? ST_FROZEN : ST_POST;
                end
            end
            ST_POST: begin
                if (wr_acc) begin
                    if (remaining_q <= 1) begin
                        remaining_d = '0;
                        state_d     = ST_FROZEN;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            ST_FROZEN: begin
                if (arm) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and read-side registers; slot storage itself is never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tail_q      <= '0;
            fill_q      <= '0;
            valid_q     <= '0;
            remaining_q <= '0;
            trig_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            has_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            fill_q      <= fill_d;
            valid_q     <= valid_d;
            remaining_q <= remaining_d;
            trig_addr_q <= trig_addr_d;
            rd_valid_q  <= rd_req;
            if (rd_req) begin
                rd_hit_q   <= valid_q[rd_slot];
                has_data_q <= 1'b1;
            end
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_hit     = rd_hit_q;
    assign data_out   = has_data_q ? ram_rd_data : '0;
    assign fill_count = fill_q;
    assign state      = state_q;
    assign trig_addr  = trig_addr_q;

endmodule

// File: tb/tb_circular_capture_buffer.sv
// tb/tb_circular_capture_buffer.sv - directed self-checking bench for circular_capture_buffer
module tb_circular_capture_buffer;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [AW-1:0] post_count = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_valid;
    logic [DW-1:0] data_out;
    logic          rd_hit;
    logic [AW:0]   fill_count;
    logic [1:0]    state;
    logic [AW-1:0] trig_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          hit;
        logic          chk_data;
    } rd_vec_t;

    rd_vec_t vec [12];

    circular_capture_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .arm       (arm),
        .trigger   (trigger),
        .post_count(post_count),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .data_out  (data_out),
        .rd_hit    (rd_hit),
        .fill_count(fill_count),
        .state     (state),
        .trig_addr (trig_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rd_vec(input int i);
        rd_req  = 1'b1;
        rd_addr = vec[i].addr;
        tick();
        rd_req  = 1'b0;
        check($sformatf("rd_valid[%0d]", i), 32'(rd_valid), 32'd1);
        check($sformatf("rd_hit[%0d]", i), 32'(rd_hit), 32'(vec[i].hit));
        if (vec[i].chk_data) begin
            check($sformatf("data_out[%0d]", i), 32'(data_out), 32'(vec[i].data));
        end
    endtask

    initial begin
        vec[0]  = '{3'd3, 8'h10, 1'b1, 1'b1};
        vec[1]  = '{3'd0, 8'h00, 1'b0, 1'b0};
        vec[2]  = '{3'd7, 8'h14, 1'b1, 1'b1};
        vec[3]  = '{3'd4, 8'h11, 1'b1, 1'b1};
        vec[4]  = '{3'd0, 8'h02, 1'b1, 1'b1};
        vec[5]  = '{3'd7, 8'h09, 1'b1, 1'b1};
        vec[6]  = '{3'd6, 8'h08, 1'b1, 1'b1};
        vec[7]  = '{3'd5, 8'h07, 1'b1, 1'b1};
        vec[8]  = '{3'd7, 8'hA3, 1'b1, 1'b1};
        vec[9]  = '{3'd6, 8'hA2, 1'b1, 1'b1};
        vec[10] = '{3'd0, 8'h06, 1'b1, 1'b1};
        vec[11] = '{3'd4, 8'hA0, 1'b1, 1'b1};

        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        rst = 1'b0;

        // Trigger in IDLE is ignored.
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("idle_trig_ignored", 32'(state), 32'd0);

        // Partial fill then reads.
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
        check("p1_fill", 32'(fill_count), 32'd5);
        for (int i = 0; i < 4; i++) rd_vec(i);
        tick();
        check("p1_rd_valid_drop", 32'(rd_valid), 32'd0);
        check("p1_data_hold", 32'(data_out), 32'h11);

        // Wraparound: tail ends at 2, buffer saturated.
        do_reset();
        for (int i = 0; i < 10; i++) wr(8'(i));
        check("p2_fill", 32'(fill_count), 32'd8);
        for (int i = 4; i < 8; i++) rd_vec(i);

        // Arm, trigger with post_count=3 and a write in the trigger cycle.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("p3_armed", 32'(state), 32'd1);
        trigger    = 1'b1;
        post_count = 3'd3;
        wr(8'hA0);
        trigger    = 1'b0;
        post_count = '0;
        check("p3_post", 32'(state), 32'd2);
        check("p3_trig_addr", 32'(trig_addr), 32'd2);
        arm = 1'b1;
        wr(8'hA1);
        arm = 1'b0;
        check("p3_arm_in_post", 32'(state), 32'd2);
        wr(8'hA2);
        check("p3_post_a2", 32'(state), 32'd2);
        wr(8'hA3);
        check("p3_frozen", 32'(state), 32'd3);
        wr(8'hA4);
        wr(8'hA5);
        check("p3_fill_held", 32'(fill_count), 32'd8);
        for (int i = 8; i < 12; i++) rd_vec(i);

        // arm+trigger in FROZEN: arm wins, writes resume.
        arm        = 1'b1;
        trigger    = 1'b1;
        post_count = 3'd2;
        tick();
        arm        = 1'b0;
        trigger    = 1'b0;
        post_count = '0;
        check("p4_arm_wins", 32'(state), 32'd1);
        wr(8'hB0);
        check("p4_still_armed", 32'(state), 32'd1);
        rd_req  = 1'b1;
        rd_addr = 3'd7;
        tick();
        rd_req  = 1'b0;
        check("p4_b0_newest", 32'(data_out), 32'hB0);

        // post_count=0 trigger: freeze directly, trigger-cycle word kept.
        trigger = 1'b1;
        wr(8'hC0);
        trigger = 1'b0;
        check("p5_frozen", 32'(state), 32'd3);
        check("p5_trig_addr", 32'(trig_addr), 32'd7);
        wr(8'hC1);
        rd_req  = 1'b1;
        rd_addr = 3'd7;
        tick();
        check("p5_c0_newest", 32'(data_out), 32'hC0);
        rd_addr = 3'd0;
        tick();
        rd_req  = 1'b0;
        check("p5_c1_dropped", 32'(data_out), 32'h08);

        // Full buffer: read oldest and overwrite it in the same cycle.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("p6_armed", 32'(state), 32'd1);
        rd_req  = 1'b1;
        rd_addr = 3'd0;
        wr(8'hD0);
        rd_req  = 1'b0;
        check("p6_rdw_old", 32'(data_out), 32'h08);
        rd_req  = 1'b1;
        rd_addr = 3'd7;
        tick();
        rd_req  = 1'b0;
        check("p6_rdw_new", 32'(data_out), 32'hD0);

        // Asynchronous reset in POST with a read in flight.
        trigger    = 1'b1;
        post_count = 3'd5;
        rd_req     = 1'b1;
        rd_addr    = 3'd0;
        tick();
        trigger    = 1'b0;
        post_count = '0;
        rd_req     = 1'b0;
        check("p7_post", 32'(state), 32'd2);
        check("p7_rd_valid", 32'(rd_valid), 32'd1);
        check("p7_data", 32'(data_out), 32'h09);
        rst = 1'b1;
        #1;
        check("p7_async_state", 32'(state), 32'd0);
        check("p7_async_fill", 32'(fill_count), 32'd0);
        check("p7_async_rd_valid", 32'(rd_valid), 32'd0);
        check("p7_async_data", 32'(data_out), 32'd0);
        check("p7_async_trig", 32'(trig_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 3'd0;
        tick();
        rd_req  = 1'b0;
        check("p7_stale_valid", 32'(rd_valid), 32'd1);
        check("p7_stale_hit", 32'(rd_hit), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
